spi_word_writer: RTL and testbench

- SPI mode-0 slave; turns host transactions into 16-bit word writes on the `spi_data` / `spi_address` / `spi_write_strobe` memory bus.
- That bus fills the frame buffer that `icnd2110_out` streams to the LED drivers, so this block sits directly upstream of it.
- Transaction format: the first 16-bit word is the start address; every following word is written at an auto-incrementing address.
- All SPI pins are oversampled in the `clk` domain; there is no second clock.

---
 rtl/led_bus_pkg.sv | 26 ++
 rtl/sync_edge.sv | 45 ++++
 rtl/spi_word_writer.sv | 202 ++++++++++++++++++++
 tb/tb_spi_word_writer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_bus_pkg.sv
// led_bus_pkg: definitions shared by the LED frame-buffer bus blocks
// (spi_word_writer on the write side, icnd2110_out on the read side).
//
// Contents:
//   WORD_COUNT         default frame buffer depth in 16-bit words
//   ADDRESS_BUS_WIDTH  default address width; the bus carries this + 1 bits
//   WORD_WIDTH         width of one frame buffer word
//   state_t            SPI writer FSM state encoding
package led_bus_pkg;

  localparam int WORD_COUNT        = 336;
  localparam int ADDRESS_BUS_WIDTH = 12;
  localparam int WORD_WIDTH        = 16;

  // WAIT_CS_HIGH : after reset, wait for an idle bus before listening
  // IDLE         : chip select high, waiting for a transaction
  // HEADER       : receiving the start-address word
  // DATA         : receiving data words, one write per word
  typedef enum logic [1:0] {
    WAIT_CS_HIGH = 2'd0,
    IDLE         = 2'd1,
    HEADER       = 2'd2,
    DATA         = 2'd3
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: brings one asynchronous pin into the clk domain through a
// two-flop synchronizer and flags its rising and falling edges.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset; every flop resets to RESET_VALUE
//   din    asynchronous input pin
//   level  synchronized level (second flop)
//   rise   one-cycle pulse when level goes 0 -> 1
//   fall   one-cycle pulse when level goes 1 -> 0
//
// Resetting the whole chain to the pin's idle value keeps a spurious edge
// from appearing at reset release while the pin sits at that idle value.
module sync_edge #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
      prev_q <= RESET_VALUE;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_word_writer.sv
// spi_word_writer: SPI mode-0 slave that turns host transactions into
// 16-bit word writes on the frame buffer bus feeding icnd2110_out.
//
// A transaction is: CS low, one 16-bit header word carrying the start
// address, then any number of 16-bit data words written at consecutive
// addresses, then CS high. Bits are MSB first, sampled on SCK rise.
// All SPI pins are oversampled in the clk domain (clk >= 4x SCK).
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   spi_sck           SPI clock pin (asynchronous)
//   spi_cs_n          SPI chip select pin, active low (asynchronous)
//   spi_mosi          SPI data pin, MSB first (asynchronous)
//   spi_data          word being written
//   spi_address       write address, ADDRESS_BUS_WIDTH+1 bits
//   spi_write_strobe  one-cycle write pulse
//   frame_done        one-cycle pulse when a transaction that wrote at
//                     least one word ends
//
// Write bus protocol: the bus has no back-pressure. spi_write_strobe is
// high for exactly one clk cycle per written word; spi_data and
// spi_address are valid in that cycle and hold until the next strobe.
// The sink must accept every strobe.
//
// The FSM state is kept in the signal `state` (type state_t) so checkers
// can bind to it.
module spi_word_writer
  import led_bus_pkg::*;
#(
  parameter int WORD_COUNT        = led_bus_pkg::WORD_COUNT,
  parameter int ADDRESS_BUS_WIDTH = led_bus_pkg::ADDRESS_BUS_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         spi_sck,
  input  logic                         spi_cs_n,
  input  logic                         spi_mosi,
  output logic [WORD_WIDTH-1:0]        spi_data,
  output logic [ADDRESS_BUS_WIDTH:0]   spi_address,
  output logic                         spi_write_strobe,
  output logic                         frame_done
);

  localparam logic [ADDRESS_BUS_WIDTH:0] WORD_LIMIT = WORD_COUNT[ADDRESS_BUS_WIDTH:0];
  localparam logic [ADDRESS_BUS_WIDTH:0] ADDR_ONE   = {{ADDRESS_BUS_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDRESS_BUS_WIDTH:0] ADDR_MAX   = '1;

  // ---------------------------------------------------------------------
  // Pin synchronizers
  // ---------------------------------------------------------------------
  logic sck_level, sck_rise, sck_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level, mosi_rise, mosi_fall;

  sync_edge #(.RESET_VALUE(1'b0)) u_sync_sck (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (spi_sck),
    .level (sck_level),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  sync_edge #(.RESET_VALUE(1'b1)) u_sync_cs (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (spi_cs_n),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  sync_edge #(.RESET_VALUE(1'b0)) u_sync_mosi (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (spi_mosi),
    .level (mosi_level),
    .rise  (mosi_rise),
    .fall  (mosi_fall)
  );

  // Edge flags this block has no use for.
  logic unused_edges;
  assign unused_edges = sck_fall ^ mosi_rise ^ mosi_fall;

  // ---------------------------------------------------------------------
  // Datapath registers and FSM
  // ---------------------------------------------------------------------
  state_t                        state;
  logic [WORD_WIDTH-1:0]         shift_reg;
  logic [3:0]                    bit_cnt;
  logic [ADDRESS_BUS_WIDTH:0]    addr_reg;
  logic                          wrote;
  logic [1:0]                    settle_cnt;

  logic                          in_frame;
  logic [WORD_WIDTH-1:0]         word_next;
  logic                          word_done;
  logic                          addr_in_range;
  logic                          write_now;
  logic [ADDRESS_BUS_WIDTH:0]    addr_inc;

  always_comb begin
    in_frame      = (state == HEADER) || (state == DATA);
    // The word as it stands once the bit arriving this cycle is shifted in.
    word_next     = {shift_reg[WORD_WIDTH-2:0], mosi_level};
    word_done     = in_frame && sck_rise && (bit_cnt == 4'd15);
    addr_in_range = (addr_reg < WORD_LIMIT);
    write_now     = word_done && (state == DATA) && addr_in_range;
    // Saturate so a long burst can never wrap back into the frame buffer.
    addr_inc      = (addr_reg == ADDR_MAX) ? ADDR_MAX : (addr_reg + ADDR_ONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= WAIT_CS_HIGH;
      shift_reg        <= '0;
      bit_cnt          <= '0;
      addr_reg         <= '0;
      wrote            <= 1'b0;
      settle_cnt       <= '0;
      spi_data         <= '0;
      spi_address      <= '0;
      spi_write_strobe <= 1'b0;
      frame_done       <= 1'b0;
    end else begin
      spi_write_strobe <= 1'b0;
      frame_done       <= 1'b0;

      case (state)
        WAIT_CS_HIGH: begin
          // The synchronizer chain resets to "CS high", so a single high
          // sample right after reset release proves nothing. Require an
          // idle bus for three consecutive cycles, by which time the
          // chain has flushed its reset value.
          if (cs_level && !sck_level) begin
            if (settle_cnt == 2'd2) begin
              state      <= IDLE;
              settle_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt + 2'd1;
            end
          end else begin
            settle_cnt <= '0;
          end
        end

        IDLE: begin
          if (cs_fall) begin
            state   <= HEADER;
            bit_cnt <= '0;
            wrote   <= 1'b0;
          end
        end

        HEADER, DATA: begin
          if (cs_fall) begin
            // A fall without a preceding rise means we missed the end of
            // the last transaction; resynchronize on a fresh header.
            state   <= HEADER;
            bit_cnt <= '0;
            wrote   <= 1'b0;
          end else begin
            if (sck_rise) begin
              shift_reg <= word_next;
              bit_cnt   <= bit_cnt + 4'd1;
            end

            if (word_done) begin
              if (state == HEADER) begin
                addr_reg <= word_next[ADDRESS_BUS_WIDTH:0];
                state    <= DATA;
              end else begin
                if (addr_in_range) begin
                  spi_data         <= word_next;
                  spi_address      <= addr_reg;
                  spi_write_strobe <= 1'b1;
                  wrote            <= 1'b1;
                end
                addr_reg <= addr_inc;
              end
            end

            // Handled after the word so a final SCK edge that lands in the
            // same cycle as CS rising still gets its word written. A
            // partial word is simply abandoned; the counter is cleared on
            // the next CS fall.
            if (cs_rise) begin
              state      <= IDLE;
              frame_done <= (state == DATA) && (wrote || write_now);
            end
          end
        end

        default: begin
          state <= WAIT_CS_HIGH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_word_writer.sv
// tb_spi_word_writer: drives SPI transactions at pin level and checks the
// frame buffer write bus against a transaction-level model.
module tb_spi_word_writer;
  import led_bus_pkg::*;

  localparam int AW       = 12;
  localparam int WC       = 336;
  localparam int CLK_P    = 10;
  localparam int W        = AW + 1 + 16;
  localparam int ADDR_MAX = (1 << (AW + 1)) - 1;

  // ---------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------
  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          spi_sck  = 1'b0;
  logic          spi_cs_n = 1'b1;
  logic          spi_mosi = 1'b0;
  logic [15:0]   spi_data;
  logic [AW:0]   spi_address;
  logic          spi_write_strobe;
  logic          frame_done;

  always #5 clk = ~clk;

  spi_word_writer #(
    .WORD_COUNT        (WC),
    .ADDRESS_BUS_WIDTH (AW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .spi_sck          (spi_sck),
    .spi_cs_n         (spi_cs_n),
    .spi_mosi         (spi_mosi),
    .spi_data         (spi_data),
    .spi_address      (spi_address),
    .spi_write_strobe (spi_write_strobe),
    .frame_done       (frame_done)
  );

  // ---------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------
  int           n_checks   = 0;
  int           n_fail     = 0;
  logic [W-1:0] exp_q[$];
  int           exp_frames = 0;
  logic [15:0]  hold_data  = '0;
  logic [AW:0]  hold_addr  = '0;
  bit           tx_bits[$];
  time          last_sck_t = 0;
  time          cs_rise_t  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Compare process: every negedge, away from the active edge
  // ---------------------------------------------------------------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    longint       d;
    if (!rst_n) begin
      hold_data = '0;
      hold_addr = '0;
      check("reset_data", 32'(spi_data), 32'd0);
      check("reset_addr", 32'(spi_address), 32'd0);
      check("reset_strobe", 32'(spi_write_strobe), 32'd0);
      check("reset_frame_done", 32'(frame_done), 32'd0);
    end else begin
      if (spi_write_strobe === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: got write addr %0d data 0x%0h, expected no write",
                   spi_address, spi_data);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 32'(spi_address), 32'(e[W-1:16]));
          check("write_data", 32'(spi_data), 32'(e[15:0]));
          hold_addr = e[W-1:16];
          hold_data = e[15:0];
          d = longint'($time - last_sck_t);
          check("strobe_latency_in_window", 32'(d >= 20 && d <= 45), 32'd1);
        end
      end else begin
        check("hold_data", 32'(spi_data), 32'(hold_data));
        check("hold_addr", 32'(spi_address), 32'(hold_addr));
        check("strobe_low", 32'(spi_write_strobe), 32'd0);
      end

      if (frame_done === 1'b1) begin
        if (exp_frames == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame_done: got pulse, expected none");
        end else begin
          exp_frames--;
          d = longint'($time - cs_rise_t);
          check("frame_done_latency_in_window", 32'(d >= 20 && d <= 45), 32'd1);
        end
      end else begin
        check("frame_done_low", 32'(frame_done), 32'd0);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Model: what a bit stream must produce on the write bus
  // ---------------------------------------------------------------------
  function automatic logic [15:0] tx_word(input int k);
    logic [15:0] w = '0;
    for (int j = 0; j < 16; j++) w = {w[14:0], tx_bits[16 * k + j]};
    return w;
  endfunction

  task automatic model_txn();
    int          nwords = tx_bits.size() / 16;
    int          addr;
    logic [15:0] w;
    logic [AW:0] a;
    bit          any_write = 0;
    if (nwords == 0) return;
    addr = int'(tx_word(0)) % (ADDR_MAX + 1);
    for (int k = 1; k < nwords; k++) begin
      w = tx_word(k);
      if (addr < WC) begin
        a = addr[AW:0];
        exp_q.push_back({a, w});
        any_write = 1;
      end
      if (addr < ADDR_MAX) addr = addr + 1;
    end
    if (any_write) exp_frames++;
  endtask

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic clk_wait(input int n);
    #(n * CLK_P);
  endtask

  task automatic push_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) tx_bits.push_back(w[i]);
  endtask

  task automatic push_rand_bits(input int n);
    for (int i = 0; i < n; i++) tx_bits.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic sck_pulse(input int half, input bit b);
    spi_mosi = b;
    clk_wait(half);
    spi_sck = 1'b1;
    clk_wait(half);
    spi_sck = 1'b0;
  endtask

  // Sends tx_bits as one transaction. With cs_last set, CS rises at the
  // same instant as the final SCK rise.
  task automatic run_txn(input int half, input bit cs_last);
    int n = tx_bits.size();
    spi_cs_n = 1'b0;
    clk_wait(half + 4);
    for (int i = 0; i < n; i++) begin
      spi_mosi = tx_bits[i];
      clk_wait(half);
      spi_sck    = 1'b1;
      last_sck_t = $time;
      if (cs_last && i == n - 1) begin
        spi_cs_n  = 1'b1;
        cs_rise_t = $time;
      end
      clk_wait(half);
      spi_sck = 1'b0;
    end
    if (!cs_last || n == 0) begin
      clk_wait(half);
      spi_cs_n  = 1'b1;
      cs_rise_t = $time;
    end
    spi_mosi = 1'b0;
    clk_wait(12);
    check("txn_writes_outstanding", 32'(exp_q.size()), 32'd0);
    check("txn_frames_outstanding", 32'(exp_frames), 32'd0);
    exp_q.delete();
    exp_frames = 0;
    tx_bits.delete();
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    int          half;
    int          nwords;
    int          partial;
    bit          cs_last;
    logic [15:0] hdr;

    #3;
    clk_wait(3);
    check("init_state", 32'(dut.state), 32'(WAIT_CS_HIGH));
    check("init_data", 32'(spi_data), 32'd0);
    check("init_strobe", 32'(spi_write_strobe), 32'd0);
    rst_n = 1'b1;
    clk_wait(8);
    check("idle_after_reset", 32'(dut.state), 32'(IDLE));

    // Basic write
    push_word(16'h0005); push_word(16'hA55A); push_word(16'h1234);
    model_txn();
    check("model_basic_count", 32'(exp_q.size()), 32'd2);
    check("model_basic_w0", 32'(exp_q[0]), 32'({13'd5, 16'hA55A}));
    check("model_basic_w1", 32'(exp_q[1]), 32'({13'd6, 16'h1234}));
    check("model_basic_frames", 32'(exp_frames), 32'd1);
    run_txn(4, 1'b0);

    // Out-of-range suppression
    push_word(16'h014E);
    for (int i = 0; i < 4; i++) push_word(16'($urandom));
    model_txn();
    check("model_oor_count", 32'(exp_q.size()), 32'd2);
    check("model_oor_a0", 32'(exp_q[0][W-1:16]), 32'd334);
    check("model_oor_a1", 32'(exp_q[1][W-1:16]), 32'd335);
    run_txn(3, 1'b0);

    // Partial trailing word
    push_word(16'h0000); push_word(16'hBEEF); push_rand_bits(9);
    model_txn();
    check("model_partial_count", 32'(exp_q.size()), 32'd1);
    check("model_partial_w0", 32'(exp_q[0]), 32'({13'd0, 16'hBEEF}));
    run_txn(4, 1'b0);

    // Header only
    push_word(16'h0010);
    model_txn();
    check("model_hdr_only_frames", 32'(exp_frames), 32'd0);
    run_txn(4, 1'b0);

    // Saturating address near all-ones must never wrap into range
    push_word(16'h1FFE);
    for (int i = 0; i < 3; i++) push_word(16'($urandom));
    model_txn();
    check("model_saturate_count", 32'(exp_q.size()), 32'd0);
    run_txn(3, 1'b0);

    // Header bits above the address width are ignored
    push_word(16'hE005); push_word(16'h5AA5);
    model_txn();
    check("model_upper_bits", 32'(exp_q[0]), 32'({13'd5, 16'h5AA5}));
    run_txn(4, 1'b0);

    // clk = 4x SCK, CS rises together with the final SCK rise
    push_word(16'h0100); push_word(16'hC0DE); push_word(16'hF00D);
    model_txn();
    check("model_ratio_count", 32'(exp_q.size()), 32'd2);
    run_txn(2, 1'b1);

    // Reset mid-stream, CS held low across release
    spi_cs_n = 1'b0;
    clk_wait(6);
    for (int i = 0; i < 10; i++) sck_pulse(3, 1'($urandom_range(0, 1)));
    rst_n = 1'b0;
    #1;
    check("async_rst_data", 32'(spi_data), 32'd0);
    check("async_rst_addr", 32'(spi_address), 32'd0);
    check("async_rst_strobe", 32'(spi_write_strobe), 32'd0);
    check("async_rst_frame_done", 32'(frame_done), 32'd0);
    check("async_rst_state", 32'(dut.state), 32'(WAIT_CS_HIGH));
    #9;
    clk_wait(3);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) sck_pulse(3, 1'($urandom_range(0, 1)));
    check("cs_low_at_release_state", 32'(dut.state), 32'(WAIT_CS_HIGH));
    spi_cs_n = 1'b1;
    clk_wait(10);
    check("cs_high_after_release_state", 32'(dut.state), 32'(IDLE));
    push_word(16'h0007); push_word(16'($urandom));
    model_txn();
    run_txn(4, 1'b0);

    // Randomized transactions
    for (int t = 0; t < 24; t++) begin
      half = $urandom_range(2, 5);
      case ($urandom_range(0, 3))
        0:       hdr = 16'($urandom_range(0, 15));
        1:       hdr = 16'($urandom_range(325, 340));
        2:       hdr = 16'($urandom);
        default: hdr = 16'($urandom_range(16'h1FFC, 16'h1FFF)) | 16'($urandom_range(0, 7) << 13);
      endcase
      nwords  = $urandom_range(0, 4);
      partial = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 15) : 0;
      cs_last = 1'($urandom_range(0, 1));
      push_word(hdr);
      for (int i = 0; i < nwords; i++) push_word(16'($urandom));
      push_rand_bits(partial);
      model_txn();
      run_txn(half, cs_last);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
